ymux_arbiter: RTL and testbench

Round-robin arbiter that shares one N-way yMux-based data path among N requesters. It sequences ownership with a request/grant/release handshake and a bounded hold time. It drives the mux select, so exactly one requester's data reaches the shared bus at a time. It sits in front of shared datapath resources (e.g. a shared write-back or memory port) in the lab CPU.

---
 rtl/ymux_arbiter_pkg.sv | 36 +++
 rtl/ymux_arbiter_if.sv | 25 ++
 rtl/ymux_arbiter_ymux_n.sv | 27 ++
 rtl/ymux_arbiter.sv | 108 ++++++++++
 tb/tb_ymux_arbiter.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/ymux_arbiter_pkg.sv
// rtl/ymux_arbiter_pkg.sv - shared constants, state type and pick helpers for ymux_arbiter
package ymux_arb_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    localparam int DEF_N        = 4;
    localparam int DEF_SELW     = 2;
    localparam int DEF_WIDTH    = 32;
    localparam int DEF_MAX_HOLD = 8;

    // Helpers work on the largest supported N; callers zero-extend and truncate.
    localparam int MAXN = 8;
    localparam int IDXW = 3;

    typedef enum logic {
        S_IDLE  = ST_IDLE,
        S_GRANT = ST_GRANT
    } arb_state_t;

    function automatic logic [MAXN-1:0] onehot(input logic [IDXW-1:0] idx);
        onehot = '0;
        onehot[idx] = 1'b1;
    endfunction

    // Zero-padded upper bits never win, so scanning mod MAXN equals scanning mod N.
    function automatic logic [IDXW-1:0] rr_pick(input logic [MAXN-1:0] req, input logic [IDXW-1:0] ptr);
        logic [IDXW-1:0] idx;
        rr_pick = ptr;
        for (int k = MAXN - 1; k >= 0; k--) begin
            idx = ptr + IDXW'(k);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/ymux_arbiter_if.sv
// rtl/ymux_arbiter_if.sv - requester/arbiter bundle for the shared yMux data path
interface ymux_arbiter_if #(
    parameter int N     = 4,
    parameter int SELW  = 2,
    parameter int WIDTH = 32
);
    logic [N-1:0]       req;
    logic [N-1:0]       done;
    logic [N*WIDTH-1:0] din;
    logic [N-1:0]       gnt;
    logic [SELW-1:0]    sel;
    logic               valid;
    logic [WIDTH-1:0]   dout;
    logic               timeout;

    modport master (
        output req, done, din,
        input  gnt, sel, valid, dout, timeout
    );

    modport slave (
        input  req, done, din,
        output gnt, sel, valid, dout, timeout
    );
endinterface

// File: rtl/ymux_arbiter_ymux_n.sv
// rtl/ymux_arbiter_ymux_n.sv - N-to-1 data mux built as a tree of 2:1 yMux stages
module ymux_n #(
    parameter int N     = 4,
    parameter int SELW  = 2,
    parameter int WIDTH = 32
) (
    input  logic [SELW-1:0]    sel,
    input  logic [N*WIDTH-1:0] din,
    output logic [WIDTH-1:0]   dout
);

    // Level l holds N>>l candidates; sel[l-1] picks within each adjacent pair.
    for (genvar l = 0; l <= SELW; l++) begin : g_lvl
        logic [(N>>l)*WIDTH-1:0] v;
        if (l == 0) begin : g_leaf
            assign v = din;
        end else begin : g_stage
            for (genvar k = 0; k < (N >> l); k++) begin : g_ymux
                assign v[k*WIDTH +: WIDTH] = sel[l-1] ? g_lvl[l-1].v[(2*k+1)*WIDTH +: WIDTH]
                                                      : g_lvl[l-1].v[(2*k)*WIDTH +: WIDTH];
            end
        end
    end

    assign dout = g_lvl[SELW].v;

endmodule

// File: rtl/ymux_arbiter.sv
// rtl/ymux_arbiter.sv - round-robin owner arbiter with bounded hold driving the shared yMux select
module ymux_arbiter
    import ymux_arb_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int SELW     = DEF_SELW,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic         clk,
    input  logic         rst,
    ymux_arbiter_if.slave bus
);

    localparam int HCW = $clog2(MAX_HOLD);

    arb_state_t      state_q, state_n;
    logic [N-1:0]    gnt_q, gnt_n;
    logic [SELW-1:0] sel_q, sel_n;
    logic [SELW-1:0] ptr_q, ptr_n;
    logic [HCW-1:0]  hold_q, hold_n;
    logic            to_q, to_n;

    logic [IDXW-1:0] winner;
    logic [MAXN-1:0] win_oh;
    logic            owner_done;
    logic            owner_drop;
    logic            hold_limit;
    logic            valid;
    logic [WIDTH-1:0] mux_out;

    always_comb begin
        winner     = rr_pick(MAXN'(bus.req), IDXW'(ptr_q));
        win_oh     = onehot(winner);
        owner_done = bus.done[sel_q];
        owner_drop = ~bus.req[sel_q];
        hold_limit = (hold_q == HCW'(MAX_HOLD - 1));

        state_n = state_q;
        gnt_n   = gnt_q;
        sel_n   = sel_q;
        ptr_n   = ptr_q;
        hold_n  = hold_q;
        to_n    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|bus.req) begin
                    gnt_n   = N'(win_oh);
                    sel_n   = SELW'(winner);
                    ptr_n   = SELW'(winner) + 1'b1;
                    hold_n  = '0;
                    state_n = S_GRANT;
                end
            end
            S_GRANT: begin
                if (owner_done || owner_drop || hold_limit) begin
                    gnt_n   = '0;
                    state_n = S_IDLE;
                    // Only a forced revoke counts as a timeout.
                    to_n    = hold_limit && !owner_done && !owner_drop;
                end else begin
                    hold_n = hold_q + 1'b1;
                end
            end
            default: begin
                gnt_n   = '0;
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_n;
            gnt_q   <= gnt_n;
            sel_q   <= sel_n;
            ptr_q   <= ptr_n;
            hold_q  <= hold_n;
            to_q    <= to_n;
        end
    end

    ymux_n #(
        .N     (N),
        .SELW  (SELW),
        .WIDTH (WIDTH)
    ) u_ymux_n (
        .sel  (sel_q),
        .din  (bus.din),
        .dout (mux_out)
    );

    assign valid       = |gnt_q;
    assign bus.gnt     = gnt_q;
    assign bus.sel     = sel_q;
    assign bus.valid   = valid;
    assign bus.timeout = to_q;
    assign bus.dout    = valid ? mux_out : '0;

endmodule

// File: tb/tb_ymux_arbiter.sv
// tb/tb_ymux_arbiter.sv - randomized and directed bench for ymux_arbiter against a behavioural model
module tb_ymux_arbiter;

    localparam int N        = 4;
    localparam int SELW     = 2;
    localparam int WIDTH    = 32;
    localparam int MAX_HOLD = 8;

    logic clk;
    logic rst;

    ymux_arbiter_if #(.N(N), .SELW(SELW), .WIDTH(WIDTH)) bus ();

    ymux_arbiter #(
        .N        (N),
        .SELW     (SELW),
        .WIDTH    (WIDTH),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    // Model: owner index (-1 when idle), cycles the owner has seen gnt, rotation pointer.
    int m_owner;
    int m_held;
    int m_ptr;
    int m_to;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit d, dr, lim, found;
        if (m_owner < 0) begin
            m_to  = 0;
            found = 0;
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (!found && bus.req[idx]) begin
                    found   = 1;
                    m_owner = idx;
                    m_held  = 1;
                    m_ptr   = (idx + 1) % N;
                end
            end
        end else begin
            d   = bus.done[m_owner];
            dr  = !bus.req[m_owner];
            lim = (m_held == MAX_HOLD);
            if (d || dr || lim) begin
                m_to    = (lim && !d && !dr) ? 1 : 0;
                m_owner = -1;
            end else begin
                m_held++;
                m_to = 0;
            end
        end
    endtask

    task automatic compare_outputs(input string tag);
        logic [N-1:0]     eg;
        logic [WIDTH-1:0] ed;
        eg = '0;
        ed = '0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            ed = bus.din[m_owner*WIDTH +: WIDTH];
        end
        chk({tag, "_gnt"},     64'(bus.gnt),     64'(eg));
        chk({tag, "_valid"},   64'(bus.valid),   64'(m_owner >= 0));
        chk({tag, "_timeout"}, 64'(bus.timeout), 64'(m_to));
        chk({tag, "_dout"},    64'(bus.dout),    64'(ed));
        if (m_owner >= 0) chk({tag, "_sel"}, 64'(bus.sel), 64'(m_owner));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_outputs(tag);
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        m_owner = -1;
        m_held  = 0;
        m_ptr   = 0;
        m_to    = 0;
        chk({tag, "_rst_gnt"},     64'(bus.gnt),     64'd0);
        chk({tag, "_rst_sel"},     64'(bus.sel),     64'd0);
        chk({tag, "_rst_valid"},   64'(bus.valid),   64'd0);
        chk({tag, "_rst_timeout"}, 64'(bus.timeout), 64'd0);
        chk({tag, "_rst_dout"},    64'(bus.dout),    64'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic rand_din();
        for (int i = 0; i < N; i++) bus.din[i*WIDTH +: WIDTH] = $urandom;
    endtask

    initial begin
        int order [6] = '{0, 1, 2, 3, 0, 1};
        int gi, cnt0, to_cnt;

        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        bus.req     = '0;
        bus.done    = '0;
        rand_din();
        @(negedge clk);

        // Reset holds everything low even with all requests up.
        bus.req = 4'b1111;
        do_reset("reset");
        bus.req = 4'b0000;

        // Single requester, released by done; then asynchronous reset mid-grant.
        bus.req = 4'b0100;
        step("single");
        chk("single_sel2", 64'(bus.sel), 64'd2);
        bus.done = 4'b0100;
        step("single_done");
        bus.done = 4'b0000;
        step("single_dead");
        chk("single_regrant", 64'(bus.gnt), 64'h4);
        do_reset("midgrant");

        // Round-robin: owner pulses done on its second grant cycle.
        bus.req = 4'b1111;
        gi = 0;
        for (int c = 0; c < 40 && gi < 6; c++) begin
            bus.done = '0;
            if (m_owner >= 0 && m_held == 2) bus.done[m_owner] = 1'b1;
            rand_din();
            step("rr");
            if (m_owner >= 0 && m_held == 1) begin
                chk("rr_order", 64'(bus.sel), 64'(order[gi]));
                gi++;
            end
        end
        chk("rr_count", 64'(gi), 64'd6);
        bus.done = '0;
        bus.req  = '0;

        // Hold limit: owner 0 is revoked after MAX_HOLD cycles, then owner 1.
        do_reset("tmo");
        bus.req = 4'b0011;
        cnt0    = 0;
        to_cnt  = 0;
        for (int c = 0; c < MAX_HOLD + 2; c++) begin
            step("tmo");
            if (bus.gnt == 4'b0001) cnt0++;
            if (bus.timeout) to_cnt++;
        end
        chk("tmo_hold_cycles", 64'(cnt0), 64'(MAX_HOLD));
        chk("tmo_pulses", 64'(to_cnt), 64'd1);
        chk("tmo_next_owner", 64'(bus.gnt), 64'h2);
        bus.req = '0;

        // done coincident with the hold limit is a normal release.
        do_reset("coin");
        bus.req = 4'b0001;
        for (int c = 0; c < 20 && !(m_owner == 0 && m_held == MAX_HOLD); c++) step("coin");
        bus.done = 4'b0001;
        step("coin_rel");
        chk("coin_timeout", 64'(bus.timeout), 64'd0);
        chk("coin_gnt", 64'(bus.gnt), 64'd0);
        bus.done = '0;
        bus.req  = '0;

        // Non-owner done/req ignored; pointer wraps 3 -> 0; req drop releases.
        do_reset("wrap");
        bus.req = 4'b1000;
        step("wrap");
        bus.done = 4'b0010;
        bus.req  = 4'b1001;
        step("wrap_ign");
        chk("wrap_owner3", 64'(bus.gnt), 64'h8);
        bus.done = 4'b0000;
        bus.req  = 4'b0001;
        step("wrap_rel");
        step("wrap_next");
        chk("wrap_owner0", 64'(bus.gnt), 64'h1);
        bus.req = 4'b0000;
        step("wrap_drop");
        chk("wrap_drop_gnt", 64'(bus.gnt), 64'd0);

        // Randomized traffic against the model.
        do_reset("rand");
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(5) == 0) bus.req[i] = ~bus.req[i];
                bus.done[i] = ($urandom_range(7) == 0);
            end
            rand_din();
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
